// File: rtl/fir_stream_sequencer.sv
// Feeds buffered upstream samples to myFIR one at a time (inputValid pulse),
// waits for outputValid and returns each result on a valid/ready stream.
module fir_stream_sequencer #(
    parameter int InputWidth    = 16,
    parameter int OutputWidth   = 38,
    parameter int FifoDepth     = 8,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [InputWidth-1:0]  s_data,
    output logic                   inputValid,
    output logic [InputWidth-1:0]  FIR_input,
    input  logic                   outputValid,
    input  logic [OutputWidth-1:0] FIR_output,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OutputWidth-1:0] m_data,
    output logic [31:0]            sample_count,
    output logic                   timeout_err
);
    // state  | meaning
    // IDLE   | wait for a buffered sample, load FIR_input from FIFO head
    // ISSUE  | inputValid pulse, FIFO pop
    // WAIT   | wait for outputValid or timeout
    // OUTPUT | hold m_valid/m_data until downstream accepts

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [PtrW:0]   FillFull = (PtrW + 1)'(FifoDepth);
    localparam logic [CntW-1:0] TmoLoad  = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t                r_state;
    state_t                w_next;

    logic [InputWidth-1:0] r_mem [FifoDepth];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [PtrW:0]         r_fill;
    logic [CntW-1:0]       r_tmo_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_done;

    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == FillFull);
    assign s_ready = !w_full;
    assign w_push  = s_valid && !w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (outputValid)           w_next = OUTPUT;
                else if (r_tmo_cnt == '0)  w_next = IDLE;
            end
            OUTPUT:  if (m_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        inputValid = 1'b0;
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE:   w_load = !w_empty;
            ISSUE: begin
                inputValid = 1'b1;
                w_pop      = 1'b1;
            end
            WAIT: begin
                w_capture = outputValid;
                w_timeout = !outputValid && (r_tmo_cnt == '0);
            end
            OUTPUT: w_done = m_valid && m_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (PtrW + 1)'(1);
                2'b01:   r_fill <= r_fill - (PtrW + 1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Down-counter loaded as WAIT is entered; terminal count 0 means the last WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_tmo_cnt <= TmoLoad;
        end else if (r_state == WAIT && !outputValid && r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            FIR_input    <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            sample_count <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (w_load)    FIR_input <= r_mem[r_rd_ptr];
            if (w_capture) begin
                m_data  <= FIR_output;
                m_valid <= 1'b1;
            end else if (w_done) begin
                m_valid <= 1'b0;
            end
            if (w_done)    sample_count <= sample_count + 32'd1;
            if (w_timeout) timeout_err  <= 1'b1;
        end
    end
endmodule

// File: doc/fir_stream_sequencer.md
Name: fir_stream_sequencer

Overview:
Hardware-side driver for the myFIR sample handshake, replacing the bench stimulus FSM in the integrated design.
- Upstream side: accepts input samples on a valid/ready stream and buffers them in a small FIFO.
- FIR side: issues each sample to the FIR as a one-cycle inputValid pulse, then waits for outputValid.
- Downstream side: presents each captured FIR result on a valid/ready output stream.
- Sits between the audio sample source and myFIR; one sample is in flight in the FIR at any time.

Parameters:
InputWidth, 16, width of input samples and of FIR_input.
OutputWidth, 38, width of FIR_output and of m_data.
FifoDepth, 8, input FIFO entries; must be a power of two and at least 2.
TimeoutCycles, 255, maximum WAIT cycles before the in-flight sample is abandoned; must be at least 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  upstream sample valid.
s_ready  out  1  upstream ready; equals !fifo_full.
s_data  in  InputWidth  upstream sample.
inputValid  out  1  one-cycle pulse to the FIR; sample on FIR_input is valid.
FIR_input  out  InputWidth  registered sample to the FIR.
outputValid  in  1  FIR result valid.
FIR_output  in  OutputWidth  FIR result.
m_valid  out  1  downstream result valid.
m_ready  in  1  downstream ready.
m_data  out  OutputWidth  registered FIR result.
sample_count  out  32  count of completed downstream handshakes; wraps modulo 2^32.
timeout_err  out  1  sticky flag; set when a timeout occurs.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, FIFO empty, inputValid=0, FIR_input=0, m_valid=0, m_data=0, sample_count=0, timeout_err=0, timeout counter=0.
  - s_ready=1 while in reset, since the FIFO is empty.
  - Reset mid-operation discards FIFO contents and any in-flight sample.
- FIFO:
  - Push on the rising edge where s_valid&&s_ready; pop on the edge that leaves ISSUE.
  - Simultaneous push and pop is legal; occupancy is unchanged.
  - When full, s_ready=0 and s_data is ignored.
  - Pointers wrap modulo FifoDepth.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
  - IDLE: if the FIFO is non-empty, load FIR_input from the FIFO head and go to ISSUE; otherwise stay.
  - ISSUE: inputValid=1 for exactly this one cycle; pop the FIFO; go to WAIT.
  - WAIT:
    - If outputValid=1: m_data<=FIR_output, m_valid<=1, go to OUTPUT.
    - Else if the timeout counter reaches TimeoutCycles-1: timeout_err<=1, go to IDLE; the sample is dropped.
    - Else increment the timeout counter.
    - The timeout counter clears on entry to WAIT.
  - OUTPUT: m_valid held at 1 and m_data held stable until m_valid&&m_ready; on that edge m_valid<=0, sample_count+1, go to IDLE.
- FIR_input holds its value from ISSUE through WAIT; it changes only when leaving IDLE.
- outputValid is ignored in IDLE, ISSUE and OUTPUT; there is no capture and no error.
- Latency:
  - A sample accepted into an empty FIFO at edge E0 gives inputValid high in the cycle after edge E1 (E1 = E0+1, the IDLE→ISSUE transition).
  - outputValid sampled high at edge W gives m_valid high in the cycle following edge W.
- Throughput: one sample per (4 + FIR latency + downstream stall) cycles.
- No arithmetic is performed on data; widths pass through unchanged.

Test Plan:
- Single sample:
  - Stimulus: push s_data=16'h0001; a FIR model returns outputValid with FIR_output=38'h5 three cycles after inputValid.
  - Required: exactly one inputValid pulse carrying FIR_input=16'h0001; m_valid rises the cycle after outputValid with m_data=38'h5; sample_count=1 after the m_ready handshake.
- Back-pressure / FIFO full:
  - Stimulus: m_ready=0, FIR result always returned; push 10 samples 1..10 with FifoDepth=8.
  - Required: s_ready goes 0 once 8 entries are buffered.
  - Required: once m_ready=1, all samples are issued in order 1..10 with no loss and no duplicates, and sample_count=10.
- Timeout:
  - Stimulus: FIR never asserts outputValid; TimeoutCycles=4.
  - Required: timeout_err=1 after 4 WAIT cycles; FSM returns to IDLE; the next FIFO sample is issued; m_valid stays 0 for the dropped sample.
- Spurious outputValid:
  - Stimulus: pulse outputValid while in IDLE and while in OUTPUT.
  - Required: m_data unchanged; no extra m_valid; sample_count unchanged.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously in WAIT with 3 samples queued.
  - Required: all outputs return to reset values immediately, without waiting for a clock edge; s_ready=1; after release, no inputValid occurs until a new sample is pushed.
- Simultaneous push and pop:
  - Stimulus: FIFO holds 1 entry; push on the same edge as the ISSUE pop.
  - Required: occupancy stays 1; the pushed sample is issued next with the correct value.
